// File: rtl/charge_pkg.sv
`default_nettype none
// -------------------------------------------------------------------
// charge_pkg : shared states, hide digit and BCD conversion helpers
// Rev 1.0
// -------------------------------------------------------------------
package charge_pkg;

  typedef enum logic [3:0] {
    ST_INIT    = 4'b0001,
    ST_START   = 4'b0010,
    ST_INPUT   = 4'b0100,
    ST_CONFIRM = 4'b1000
  } state_e;

  localparam logic [3:0] HIDE = 4'hF;

  // Up to 16 BCD digits; callers truncate to their own width.
  function automatic logic [63:0] bin2bcd(input logic [31:0] bin);
    logic [31:0] v;
    logic [63:0] r;
    v = bin;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(v % 32'd10);
      v = v / 32'd10;
    end
    return r;
  endfunction

  function automatic logic [31:0] bcd2bin(input logic [7:0] bcd);
    return 32'(bcd[7:4]) * 32'd10 + 32'(bcd[3:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/charge_channel.sv
`default_nettype none
// -------------------------------------------------------------------
// charge_channel : one BCD countdown timer with prescaler, busy, done
// Rev 1.0
// -------------------------------------------------------------------
module charge_channel
  import charge_pkg::*;
#(
  parameter int TDIG     = 3,
  parameter int TICK_DIV = 256
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              load,
  input  logic [4*TDIG-1:0] load_val,
  output logic [4*TDIG-1:0] timer,
  output logic              busy,
  output logic              done
);

  localparam int TW = 4 * TDIG;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] ONE        = TW'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < TDIG; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'h0) begin
          r[4*i +: 4] = 4'h9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'h1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    timer_d = timer_q;
    presc_d = presc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (load) begin
      timer_d = load_val;
      presc_d = '0;
      busy_d  = (load_val != '0);
    end else if (busy_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        timer_d = bcd_dec(timer_q);
        if (timer_q == ONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      timer_q <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign timer = timer_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: rtl/charge_station_ctrl.sv
`default_nettype none
// -------------------------------------------------------------------
// charge_station_ctrl : prepaid keypad front end driving NCH timers
// Rev 1.0
// -------------------------------------------------------------------
module charge_station_ctrl
  import charge_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int RATE      = 2,
  parameter int MAX_MONEY = 20,
  parameter int TDIG      = 3,
  parameter int TICK_DIV  = 256,
  parameter int TIMEOUT   = 4096,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              ok,
  input  logic              clear,
  input  logic              idle,
  input  logic [3:0]        data,
  input  logic [CW-1:0]     ch_sel,
  output logic [7:0]        money,
  output logic [4*TDIG-1:0] preview,
  output logic [4*TDIG-1:0] timer_sel,
  output logic [NCH-1:0]    ch_busy,
  output logic [NCH-1:0]    ch_done,
  output logic              err,
  output logic [3:0]        state_viewer
);

  localparam int TW = 4 * TDIG;
  localparam int KW = $clog2(TIMEOUT) + 1;
  localparam logic [7:0]    MAX_BCD  = 8'(bin2bcd(32'(MAX_MONEY)));
  localparam logic [TW-1:0] HIDE_ALL = {TDIG{HIDE}};

  state_e        state_q, state_d;
  logic [7:0]    money_q, money_d;
  logic [KW-1:0] idle_cnt_q, idle_cnt_d;
  logic          prev_idle_q;
  logic          err_q, err_d;

  logic [TW-1:0]  charge_bcd;
  logic [7:0]     candidate;
  logic           keypress, timeout, accept, sel_busy;
  logic [TW-1:0]  sel_timer;
  logic [TW-1:0]  timers [NCH];
  logic [NCH-1:0] busy_vec, done_vec;

  assign charge_bcd = TW'(bin2bcd(bcd2bin(money_q) * 32'(RATE)));
  assign candidate  = {money_q[3:0], data};
  assign keypress   = (state_q == ST_INPUT) && prev_idle_q && !idle && (data != HIDE);
  assign timeout    = (idle_cnt_q == KW'(TIMEOUT - 1));

  // Loop mux keeps non-power-of-two NCH from indexing past the array.
  always_comb begin
    sel_busy  = 1'b0;
    sel_timer = HIDE_ALL;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == CW'(i)) begin
        sel_busy  = busy_vec[i];
        sel_timer = timers[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    money_d    = money_q;
    idle_cnt_d = idle_cnt_q;
    err_d      = 1'b0;
    accept     = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (start) begin
          state_d    = ST_START;
          money_d    = 8'h00;
          idle_cnt_d = '0;
        end
      end
      ST_START: state_d = ST_INPUT;
      ST_INPUT: begin
        idle_cnt_d = idle ? idle_cnt_q + 1'b1 : '0;
        if (timeout) begin
          state_d    = ST_INIT;
          money_d    = 8'hFF;
          idle_cnt_d = '0;
        end else if (ok) begin
          if (money_q != 8'h00) begin
            if (sel_busy) begin
              err_d = 1'b1;
            end else begin
              accept  = 1'b1;
              state_d = ST_CONFIRM;
            end
          end
        end else if (keypress) begin
          // Only a single-digit amount can take another digit.
          if (money_q[7:4] == 4'h0) begin
            money_d = (bcd2bin(candidate) > 32'(MAX_MONEY)) ? MAX_BCD : candidate;
          end
        end else if (clear) begin
          money_d = 8'h00;
        end
      end
      ST_CONFIRM: begin
        state_d    = ST_START;
        money_d    = 8'h00;
        idle_cnt_d = '0;
      end
      default: begin
        state_d    = ST_INIT;
        money_d    = 8'hFF;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= ST_INIT;
      money_q     <= 8'hFF;
      idle_cnt_q  <= '0;
      prev_idle_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      money_q     <= money_d;
      idle_cnt_q  <= idle_cnt_d;
      prev_idle_q <= idle;
      err_q       <= err_d;
    end
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      charge_channel #(
        .TDIG     (TDIG),
        .TICK_DIV (TICK_DIV)
      ) u_ch (
        .CLK      (CLK),
        .rst      (rst),
        .load     (accept && (ch_sel == CW'(i))),
        .load_val (charge_bcd),
        .timer    (timers[i]),
        .busy     (busy_vec[i]),
        .done     (done_vec[i])
      );
    end
  endgenerate

  assign money        = money_q;
  assign preview      = (state_q == ST_INIT) ? HIDE_ALL : charge_bcd;
  assign timer_sel    = (state_q == ST_INIT) ? HIDE_ALL : sel_timer;
  assign ch_busy      = busy_vec;
  assign ch_done      = done_vec;
  assign err          = err_q;
  assign state_viewer = state_q;

endmodule
`default_nettype wire

// File: doc/charge_station_ctrl.md
CHARGE_STATION_CTRL -- requirements
Module: charge_station_ctrl

Interface
REQ-001 SHALL have parameter NCH, 4, number of independent charging channels (1..16).
REQ-002 SHALL have parameter RATE, 2, minutes granted per money unit.
REQ-003 SHALL have parameter MAX_MONEY, 20, money cap (decimal, <=99; MAX_MONEY*RATE <= 10^TDIG-1).
REQ-004 SHALL have parameter TDIG, 3, BCD digits per channel timer.
REQ-005 SHALL have parameter TICK_DIV, 256, CLK cycles per timer decrement.
REQ-006 SHALL have parameter TIMEOUT, 4096, idle-key cycles in INPUT before abort.
REQ-007 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have ports start input 1 (begin session); ok input 1 (confirm); clear input 1 (zero entry).
REQ-010 SHALL have port idle  input  1  keypad idle flag; 1->0 transition = one keypress.
REQ-011 SHALL have port data  input  4  BCD key digit; 4'hF = invalid, ignored.
REQ-012 SHALL have port ch_sel  input  clog2(NCH), min 1  target channel, sampled on ok.
REQ-013 SHALL have port money  output  8  entered amount, 2 BCD digits; 8'hFF = hidden.
REQ-014 SHALL have port preview  output  4*TDIG  BCD minutes for current money; all-F = hidden.
REQ-015 SHALL have port timer_sel  output  4*TDIG  BCD remaining minutes of channel ch_sel; all-F in INIT.
REQ-016 SHALL have ports ch_busy output NCH (level); ch_done output NCH (1-cycle pulse); err output 1 (1-cycle pulse).
REQ-017 SHALL have port state_viewer  output  4  one-hot: INIT 0001, START 0010, INPUT 0100, CONFIRM 1000.

Function
REQ-018 Front FSM SHALL be INIT->(start)->START->INPUT->(accepted ok)->CONFIRM->START; START and CONFIRM last one cycle each.
REQ-019 START SHALL clear money to 8'h00 and the idle counter.
REQ-020 Keypress SHALL be detected when previous-cycle idle=1 and current idle=0 with data!=4'hF, in INPUT only.
REQ-021 On keypress: tens digit !=0 -> ignored; else candidate = {ones,data}; candidate > MAX_MONEY -> money = MAX_MONEY (BCD); else money = candidate.
REQ-022 clear in INPUT SHALL set money to 8'h00; a same-cycle keypress SHALL take priority over clear.
REQ-023 Idle counter SHALL increment each INPUT cycle with idle=1, reset to 0 otherwise; reaching TIMEOUT-1 SHALL force INIT.
REQ-024 Priority within INPUT SHALL be: timeout > ok > keypress > clear.
REQ-025 ok with money=0 SHALL be ignored; ok with ch_busy[ch_sel]=1 SHALL pulse err and stay in INPUT, money kept.
REQ-026 Accepted ok SHALL load channel ch_sel with BCD(money*RATE) and restart its prescaler; ch_busy high from the following cycle.
REQ-027 preview SHALL equal BCD(money*RATE) combinationally outside INIT.
REQ-028 Each busy channel SHALL decrement its BCD timer by 1 every TICK_DIV cycles, with digit borrow (e.g. 100->099).
REQ-029 On decrement to 0: ch_busy low and ch_done pulse in the same cycle; timer stays 0.
REQ-030 Channels SHALL run concurrently and independently of the front FSM state, including INIT.
REQ-031 start outside INIT SHALL be ignored; unused FSM encodings SHALL return to INIT.

Reset
REQ-032 rst SHALL set FSM=INIT, money=8'hFF, all timers 0, ch_busy=0, ch_done=0, err=0, prescalers and idle counter 0, previous-idle register 1.
REQ-033 rst mid-charge SHALL abort all channels without asserting ch_done.

Structure
REQ-034 State encodings, HIDE digit 4'hF and the binary<->BCD conversion functions SHALL live in package charge_pkg.
REQ-035 Per-channel timer, prescaler, busy and done logic SHALL be sub-module charge_channel, instantiated NCH times via generate.

Verification
REQ-036 start, keys 1,5, ok, ch_sel=2 -> money 8'h15, preview 12'h030, ch_busy[2]=1, state_viewer 1000 for one cycle then 0010.
REQ-037 Keys 2,5 -> money 8'h20 (capped), preview 12'h040; third key 7 -> ignored.
REQ-038 Load ch0 with money 1 -> ch_done[0] pulses exactly 2*256 cycles after load, timer_sel 002->001->000.
REQ-039 ok to busy ch1 -> err pulse, ch1 timer unchanged, FSM stays INPUT; ok with money 0 -> no effect.
REQ-040 INPUT with idle held 1 for 4096 cycles -> INIT, money 8'hFF; rst mid-charge -> all ch_busy 0, no ch_done.
